fetch_unit: RTL

Instruction fetch stage directly upstream of the control unit. Holds the program counter, issues word reads to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions with their PCs in an in-order queue. Presents the head instruction together with its opcode, funct3 and funct7 bit 5 fields to decode. Accepts taken-branch/jump redirects from execute and flushes all wrong-path work.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over req/gnt/rvalid,
// and queues returned instructions with their PCs for decode in program order.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [6:0]  op_o,
   output logic [2:0]  funct3_o,
   output logic        funct7_b5_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [31:0]      fpc_q, fpc_d;
   logic [AW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
   logic [CW-1:0]    count_q, count_d, pend_q, pend_d;
   logic [7:0]       drop_q, drop_d;
   logic [DEPTH-1:0] filled_q, filled_d;
   logic [31:0]      pc_mem_q    [DEPTH];
   logic [31:0]      instr_mem_q [DEPTH];
   logic             xfer_s, pop_s, rv_drop_s, rv_fill_s;

   // count_q covers every reserved slot, filled or still awaiting data
   assign imem_req_o    = !rst_i && (count_q < CW'(DEPTH));
   assign imem_addr_o   = fpc_q;
   assign instr_valid_o = filled_q[head_q];
   assign instr_o       = instr_mem_q[head_q];
   assign pc_o          = pc_mem_q[head_q];
   assign pc_plus4_o    = pc_o + 32'd4;
   assign op_o          = instr_o[6:0];
   assign funct3_o      = instr_o[14:12];
   assign funct7_b5_o   = instr_o[30];

   always_comb begin
      xfer_s    = imem_req_o & imem_gnt_i;
      rv_drop_s = imem_rvalid_i && (drop_q != 8'd0);
      rv_fill_s = imem_rvalid_i && (drop_q == 8'd0) && (pend_q != {CW{1'b0}});
      pop_s     = instr_valid_o & ~stall_i;
      fpc_d     = fpc_q;
      head_d    = head_q;
      tail_d    = tail_q;
      fill_d    = fill_q;
      count_d   = count_q;
      pend_d    = pend_q;
      drop_d    = drop_q;
      filled_d  = filled_q;
      if (redirect_i) begin
         // everything still in flight after this cycle, including a grant now, must be dropped
         fpc_d    = {redirect_pc_i[31:2], 2'b00};
         head_d   = {AW{1'b0}};
         tail_d   = {AW{1'b0}};
         fill_d   = {AW{1'b0}};
         count_d  = {CW{1'b0}};
         pend_d   = {CW{1'b0}};
         filled_d = {DEPTH{1'b0}};
         drop_d   = drop_q - 8'(rv_drop_s) + 8'(pend_q) - 8'(rv_fill_s) + 8'(xfer_s);
      end else begin
         if (xfer_s) begin
            fpc_d  = fpc_q + 32'd4;
            tail_d = tail_q + 1'b1;
         end
         if (rv_fill_s) begin
            filled_d[fill_q] = 1'b1;
            fill_d           = fill_q + 1'b1;
         end
         if (pop_s) begin
            filled_d[head_q] = 1'b0;
            head_d           = head_q + 1'b1;
         end
         count_d = count_q + CW'(xfer_s) - CW'(pop_s);
         pend_d  = pend_q + CW'(xfer_s) - CW'(rv_fill_s);
         drop_d  = drop_q - 8'(rv_drop_s);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fpc_q    <= RESET_PC;
         head_q   <= {AW{1'b0}};
         tail_q   <= {AW{1'b0}};
         fill_q   <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
         pend_q   <= {CW{1'b0}};
         drop_q   <= 8'd0;
         filled_q <= {DEPTH{1'b0}};
      end else begin
         fpc_q    <= fpc_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         fill_q   <= fill_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         drop_q   <= drop_d;
         filled_q <= filled_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= 32'd0;
            instr_mem_q[i] <= 32'd0;
         end
      end else begin
         if (!redirect_i && xfer_s) pc_mem_q[tail_q] <= fpc_q;
         if (!redirect_i && rv_fill_s) instr_mem_q[fill_q] <= imem_rdata_i;
      end
   end
endmodule
